schematic_ctrl_fsm: RTL and testbench

- Multi-cycle control unit for the team's 16-bit CSSE232 processor.
- Decodes the 4-bit opcode held in the instruction register and sequences a 5-bit Moore state machine.
- Drives every datapath strobe and mux select.
- Contains the hardware/software interrupt front end: edge detect, pending capture, EPC save, vectoring.

---
 rtl/schematic_ctrl_fsm_pkg.sv | 87 ++++++++
 rtl/schematic_ctrl_fsm_int_capture.sv | 67 ++++++
 rtl/schematic_ctrl_fsm.sv | 189 ++++++++++++++++++
 tb/tb_schematic_ctrl_fsm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/schematic_ctrl_fsm_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared state encoding, opcodes, select codes and vector select
//            for the schematic_ctrl_fsm multi-cycle control unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_EXEC_R   = 5'd2,
        S_RWB      = 5'd3,
        S_EXEC_I   = 5'd4,
        S_IWB      = 5'd5,
        S_ADDR     = 5'd6,
        S_MEMRD    = 5'd7,
        S_LWB      = 5'd8,
        S_MEMWR    = 5'd9,
        S_BEQ      = 5'd10,
        S_BNE      = 5'd11,
        S_JUMP     = 5'd12,
        S_JAL      = 5'd13,
        S_JR       = 5'd14,
        S_LUI      = 5'd15,
        S_IRET     = 5'd16,
        S_INT_SAVE = 5'd17,
        S_INT_JUMP = 5'd18
    } state_t;

    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_J    = 4'd9;
    localparam logic [3:0] OP_JAL  = 4'd10;
    localparam logic [3:0] OP_JR   = 4'd11;
    localparam logic [3:0] OP_LUI  = 4'd12;
    localparam logic [3:0] OP_IRET = 4'd13;
    localparam logic [3:0] OP_TRAP = 4'd14;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_SLT   = 4'd4;
    localparam logic [3:0] ALU_PASSB = 4'd5;

    localparam logic [2:0] PC_ALU    = 3'd0;
    localparam logic [2:0] PC_ALUOUT = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_VEC    = 3'd3;
    localparam logic [2:0] PC_EPC    = 3'd4;
    localparam logic [2:0] PC_REGA   = 3'd5;

    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;
    localparam logic [1:0] WD_IMM8   = 2'd3;

    localparam logic [2:0] VEC_SEL = PC_VEC;
    localparam int         NUM_HWI = 8;

    // Opcodes 0-3 are all R-type; the low two bits become the ALU op.
    function automatic state_t dispatch(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: return S_EXEC_R;
            OP_ADDI:                return S_EXEC_I;
            OP_LW, OP_SW:           return S_ADDR;
            OP_BEQ:                 return S_BEQ;
            OP_BNE:                 return S_BNE;
            OP_J:                   return S_JUMP;
            OP_JAL:                 return S_JAL;
            OP_JR:                  return S_JR;
            OP_LUI:                 return S_LUI;
            OP_IRET:                return S_IRET;
            OP_TRAP:                return S_INT_SAVE;
            default:                return S_FETCH;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/schematic_ctrl_fsm_int_capture.sv
// ============================================================================
// Module   : int_capture
// Brief    : Interrupt front end: edge detect, pending capture, cause latch
//            and in-service flag. Hardware path enabled by CTRL_HW_INT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module int_capture #(
    parameter int NUM_HWI = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_HWI-1:0] i_hwInt,
    input  logic               i_save,
    input  logic               i_iret,
    output logic [NUM_HWI-1:0] o_pending,
    output logic [NUM_HWI-1:0] o_flipped,
    output logic               o_inService
);

    logic [NUM_HWI-1:0] r_flipped;
    logic               r_inService;

`ifdef CTRL_HW_INT_EN
    logic [NUM_HWI-1:0] r_hwQ;
    logic [NUM_HWI-1:0] r_pending;
    logic [NUM_HWI-1:0] w_edge;

    assign w_edge = i_hwInt & ~r_hwQ;

    // A rising edge in the save cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hwQ     <= '0;
            r_pending <= '0;
        end else begin
            r_hwQ     <= i_hwInt;
            r_pending <= i_save ? w_edge : (r_pending | w_edge);
        end
    end

    assign o_pending = r_pending;
`else
    logic w_unusedHw;
    assign w_unusedHw = ^i_hwInt;
    assign o_pending  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flipped   <= '0;
            r_inService <= 1'b0;
        end else if (i_save) begin
            r_flipped   <= o_pending;
            r_inService <= 1'b1;
        end else if (i_iret) begin
            r_inService <= 1'b0;
        end
    end

    assign o_flipped   = r_flipped;
    assign o_inService = r_inService;

endmodule

`default_nettype wire

// File: rtl/schematic_ctrl_fsm.sv
// ============================================================================
// Module   : schematic_ctrl_fsm
// Brief    : Multi-cycle Moore control unit for the 16-bit processor with
//            interrupt sequencing. Hardware interrupts need CTRL_HW_INT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module schematic_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic               CLK,
    input  logic               Reset,
    input  logic [3:0]         Opcode,
    input  logic               InterruptIn,
    input  logic [NUM_HWI-1:0] HardwareInterrupt,
    output logic [4:0]         next_state,
    output logic [4:0]         current_state,
    output logic [3:0]         ALUOp,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               SignExt,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [2:0]         IorD,
    output logic [1:0]         MemWriteData,
    output logic               IRegWrite,
    output logic               GRegWrite,
    output logic [1:0]         WriteAddr,
    output logic [1:0]         WriteData,
    output logic               PCWrite,
    output logic               PCWriteBeq,
    output logic               PCWriteBne,
    output logic [2:0]         PCData,
    output logic               EPCWrite,
    output logic               InterruptWrite,
    output logic               FlippedWrite,
    output logic               InterruptTrue,
    output logic [NUM_HWI-1:0] Flipped
);

    state_t             r_state;
    state_t             w_next;
    logic [NUM_HWI-1:0] w_pending;
    logic               w_inService;
    logic               w_intTrue;

    int_capture #(.NUM_HWI(NUM_HWI)) u_intCapture (
        .clk         (CLK),
        .rst         (Reset),
        .i_hwInt     (HardwareInterrupt),
        .i_save      (r_state == S_INT_SAVE),
        .i_iret      (r_state == S_IRET),
        .o_pending   (w_pending),
        .o_flipped   (Flipped),
        .o_inService (w_inService)
    );

`ifdef CTRL_HW_INT_EN
    assign w_intTrue = InterruptIn & ~w_inService & (|w_pending);
`else
    logic w_unusedInt;
    assign w_unusedInt = InterruptIn ^ w_inService ^ (|w_pending);
    assign w_intTrue   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next         = S_FETCH;
        ALUOp          = ALU_ADD;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 2'd0;
        SignExt        = 1'b0;
        MemRead        = 1'b0;
        MemWrite       = 1'b0;
        IorD           = 3'd0;
        MemWriteData   = 2'd0;
        IRegWrite      = 1'b0;
        GRegWrite      = 1'b0;
        WriteAddr      = 2'd0;
        WriteData      = WD_ALUOUT;
        PCWrite        = 1'b0;
        PCWriteBeq     = 1'b0;
        PCWriteBne     = 1'b0;
        PCData         = PC_ALU;
        EPCWrite       = 1'b0;
        InterruptWrite = 1'b0;
        FlippedWrite   = 1'b0;
        case (r_state)
            // Only Mealy term: a pending interrupt suppresses the fetch.
            S_FETCH: begin
                MemRead   = ~w_intTrue;
                IRegWrite = ~w_intTrue;
                PCWrite   = ~w_intTrue;
                ALUSrcB   = 2'd1;
                w_next    = w_intTrue ? S_INT_SAVE : S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'd3;
                SignExt = 1'b1;
                w_next  = dispatch(Opcode);
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = {2'b00, Opcode[1:0]};
                w_next  = S_RWB;
            end
            S_RWB: GRegWrite = 1'b1;
            S_EXEC_I, S_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                SignExt = 1'b1;
                if (r_state == S_EXEC_I) w_next = S_IWB;
                else                     w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_IWB: begin
                GRegWrite = 1'b1;
                WriteAddr = 2'd1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 3'd1;
                w_next  = S_LWB;
            end
            S_LWB: begin
                GRegWrite = 1'b1;
                WriteAddr = 2'd1;
                WriteData = WD_MDR;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 3'd1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALU_SUB;
                PCWriteBeq = (r_state == S_BEQ);
                PCWriteBne = (r_state == S_BNE);
                PCData     = PC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCData  = PC_JUMP;
            end
            S_JAL: begin
                GRegWrite = 1'b1;
                WriteAddr = 2'd2;
                WriteData = WD_PC;
                PCWrite   = 1'b1;
                PCData    = PC_JUMP;
            end
            S_JR: begin
                PCWrite = 1'b1;
                PCData  = PC_REGA;
            end
            S_LUI: begin
                GRegWrite = 1'b1;
                WriteAddr = 2'd1;
                WriteData = WD_IMM8;
            end
            S_IRET: begin
                PCWrite = 1'b1;
                PCData  = PC_EPC;
            end
            S_INT_SAVE: begin
                EPCWrite       = 1'b1;
                InterruptWrite = 1'b1;
                FlippedWrite   = 1'b1;
                w_next         = S_INT_JUMP;
            end
            S_INT_JUMP: begin
                PCWrite = 1'b1;
                PCData  = VEC_SEL;
            end
            default: ;
        endcase
    end

    assign next_state    = w_next;
    assign current_state = r_state;
    assign InterruptTrue = w_intTrue;

endmodule

`default_nettype wire

// File: tb/tb_schematic_ctrl_fsm.sv
// ============================================================================
// Module   : tb_schematic_ctrl_fsm
// Brief    : Scoreboard bench for schematic_ctrl_fsm; hardware interrupt
//            scenarios depend on CTRL_HW_INT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_schematic_ctrl_fsm;
    import ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [3:0] Opcode;
    logic       InterruptIn;
    logic [7:0] HardwareInterrupt;
    logic [4:0] next_state, current_state;
    logic [3:0] ALUOp;
    logic       ALUSrcA, SignExt, MemRead, MemWrite, IRegWrite, GRegWrite;
    logic [1:0] ALUSrcB, MemWriteData, WriteAddr, WriteData;
    logic [2:0] IorD, PCData;
    logic       PCWrite, PCWriteBeq, PCWriteBne, EPCWrite, InterruptWrite, FlippedWrite;
    logic       InterruptTrue;
    logic [7:0] Flipped;

    schematic_ctrl_fsm dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .InterruptIn(InterruptIn),
        .HardwareInterrupt(HardwareInterrupt), .next_state(next_state),
        .current_state(current_state), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .SignExt(SignExt), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .MemWriteData(MemWriteData), .IRegWrite(IRegWrite),
        .GRegWrite(GRegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .PCWrite(PCWrite), .PCWriteBeq(PCWriteBeq), .PCWriteBne(PCWriteBne),
        .PCData(PCData), .EPCWrite(EPCWrite), .InterruptWrite(InterruptWrite),
        .FlippedWrite(FlippedWrite), .InterruptTrue(InterruptTrue), .Flipped(Flipped)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic [29:0] actCtl;
    assign actCtl = {ALUOp, ALUSrcA, ALUSrcB, SignExt, MemRead, MemWrite, IorD,
                     MemWriteData, IRegWrite, GRegWrite, WriteAddr, WriteData,
                     PCWrite, PCWriteBeq, PCWriteBne, PCData, EPCWrite,
                     InterruptWrite, FlippedWrite};

    typedef struct packed {
        logic [4:0]  st;
        logic [29:0] ctl;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected control word per state, written from the state table.
    function automatic logic [29:0] expCtl(input logic [4:0] st, input logic it, input logic [3:0] op);
        logic [3:0] aluOp = 4'd0;
        logic       srcA = 1'b0, sx = 1'b0, mr = 1'b0, mw = 1'b0, irw = 1'b0, grw = 1'b0;
        logic [1:0] srcB = 2'd0, mwd = 2'd0, wa = 2'd0, wd = 2'd0;
        logic [2:0] iord = 3'd0, pcd = 3'd0;
        logic       pcw = 1'b0, beq = 1'b0, bne = 1'b0, epc = 1'b0, iw = 1'b0, fw = 1'b0;
        case (st)
            5'd0:  begin mr = !it; irw = !it; pcw = !it; srcB = 2'd1; end
            5'd1:  begin srcB = 2'd3; sx = 1'b1; end
            5'd2:  begin srcA = 1'b1; aluOp = {2'b00, op[1:0]}; end
            5'd3:  grw = 1'b1;
            5'd4, 5'd6: begin srcA = 1'b1; srcB = 2'd2; sx = 1'b1; end
            5'd5:  begin grw = 1'b1; wa = 2'd1; end
            5'd7:  begin mr = 1'b1; iord = 3'd1; end
            5'd8:  begin grw = 1'b1; wa = 2'd1; wd = 2'd1; end
            5'd9:  begin mw = 1'b1; iord = 3'd1; end
            5'd10: begin srcA = 1'b1; aluOp = 4'd1; beq = 1'b1; pcd = 3'd1; end
            5'd11: begin srcA = 1'b1; aluOp = 4'd1; bne = 1'b1; pcd = 3'd1; end
            5'd12: begin pcw = 1'b1; pcd = 3'd2; end
            5'd13: begin grw = 1'b1; wa = 2'd2; wd = 2'd2; pcw = 1'b1; pcd = 3'd2; end
            5'd14: begin pcw = 1'b1; pcd = 3'd5; end
            5'd15: begin grw = 1'b1; wa = 2'd1; wd = 2'd3; end
            5'd16: begin pcw = 1'b1; pcd = 3'd4; end
            5'd17: begin epc = 1'b1; iw = 1'b1; fw = 1'b1; end
            5'd18: begin pcw = 1'b1; pcd = 3'd3; end
            default: ;
        endcase
        return {aluOp, srcA, srcB, sx, mr, mw, iord, mwd, irw, grw, wa, wd,
                pcw, beq, bne, pcd, epc, iw, fw};
    endfunction

    function automatic logic [4:0] expNext(input logic [4:0] st, input logic [3:0] op, input logic it);
        case (st)
            5'd0: return it ? 5'd17 : 5'd1;
            5'd1: case (op)
                      4'd0, 4'd1, 4'd2, 4'd3: return 5'd2;
                      4'd4:  return 5'd4;
                      4'd5, 4'd6: return 5'd6;
                      4'd7:  return 5'd10;
                      4'd8:  return 5'd11;
                      4'd9:  return 5'd12;
                      4'd10: return 5'd13;
                      4'd11: return 5'd14;
                      4'd12: return 5'd15;
                      4'd13: return 5'd16;
                      4'd14: return 5'd17;
                      default: return 5'd0;
                  endcase
            5'd2:  return 5'd3;
            5'd4:  return 5'd5;
            5'd6:  return (op == 4'd5) ? 5'd7 : 5'd9;
            5'd7:  return 5'd8;
            5'd17: return 5'd18;
            default: return 5'd0;
        endcase
    endfunction

    task automatic pushExp(input logic [4:0] st, input logic it, input logic [3:0] op);
        exp_t e;
        e.st  = st;
        e.ctl = expCtl(st, it, op);
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("state@%0d", e.st), {27'd0, current_state}, {27'd0, e.st});
            chk($sformatf("ctl@%0d", e.st), {2'd0, actCtl}, {2'd0, e.ctl});
            if (sb.size() > 0)
                chk($sformatf("next@%0d", e.st), {27'd0, next_state}, {27'd0, sb[0].st});
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic runInstr(input logic [3:0] op);
        logic [4:0] st;
        st     = 5'd0;
        Opcode = op;
        for (int i = 0; i < 8; i++) begin
            pushExp(st, 1'b0, op);
            st = expNext(st, op, 1'b0);
            if (st == 5'd0) break;
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] ops [12];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12};

        Reset = 1'b1; Opcode = 4'd0; InterruptIn = 1'b0; HardwareInterrupt = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_state", {27'd0, current_state}, 32'd0);
        chk("reset_flipped", {24'd0, Flipped}, 32'd0);
        chk("reset_inttrue", {31'd0, InterruptTrue}, 32'd0);
        chk("reset_ctl", {2'd0, actCtl}, {2'd0, expCtl(5'd0, 1'b0, 4'd0)});
        Reset = 1'b0;

        foreach (ops[i]) runInstr(ops[i]);
        runInstr(4'd11);
        runInstr(4'd15);

        runInstr(4'd14);
        chk("trap_flipped", {24'd0, Flipped}, 32'd0);
        runInstr(4'd13);

`ifdef CTRL_HW_INT_EN
        InterruptIn = 1'b1;
        Opcode = 4'd0;
        pushExp(5'd0, 1'b0, 4'd0);
        pushExp(5'd1, 1'b0, 4'd0);
        drain();
        HardwareInterrupt = 8'h04;
        pushExp(5'd2, 1'b0, 4'd0);
        pushExp(5'd3, 1'b0, 4'd0);
        drain();
        chk("hw_inttrue", {31'd0, InterruptTrue}, 32'd1);
        pushExp(5'd0, 1'b1, 4'd0);
        pushExp(5'd17, 1'b0, 4'd0);
        pushExp(5'd18, 1'b0, 4'd0);
        drain();
        chk("hw_flipped", {24'd0, Flipped}, 32'h04);
        chk("hw_cleared", {31'd0, InterruptTrue}, 32'd0);

        HardwareInterrupt = 8'h05;
        runInstr(4'd0);
        chk("nest_blocked", {31'd0, InterruptTrue}, 32'd0);
        Opcode = 4'd13;
        pushExp(5'd0, 1'b0, 4'd13);
        pushExp(5'd1, 1'b0, 4'd13);
        pushExp(5'd16, 1'b0, 4'd13);
        pushExp(5'd0, 1'b1, 4'd13);
        pushExp(5'd17, 1'b0, 4'd13);
        pushExp(5'd18, 1'b0, 4'd13);
        drain();
        chk("iret_flipped", {24'd0, Flipped}, 32'h01);
`else
        InterruptIn = 1'b1;
        HardwareInterrupt = 8'h04;
        runInstr(4'd0);
        chk("hw_ignored", {31'd0, InterruptTrue}, 32'd0);
        runInstr(4'd0);
        chk("hw_flipped0", {24'd0, Flipped}, 32'd0);
`endif

        InterruptIn = 1'b0;
        Opcode = 4'd5;
        pushExp(5'd0, 1'b0, 4'd5);
        pushExp(5'd1, 1'b0, 4'd5);
        pushExp(5'd6, 1'b0, 4'd5);
        drain();
        pushExp(5'd7, 1'b0, 4'd5);
        Reset = 1'b1;
        drain();
        chk("midreset_state", {27'd0, current_state}, 32'd0);
        chk("midreset_flipped", {24'd0, Flipped}, 32'd0);
        Reset = 1'b0;
        runInstr(4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
